mips_cpu_muldiv_seq: RTL

- Responder end of the ALU's HI/LO interface: executes MULT/MULTU/DIV/DIVU iteratively and owns the HI/LO architectural registers.
- Services MTHI/MTLO writes, and presents hi/lo continuously for the ALU's MFHI/MFLO result muxing.
- Reports a busy/done handshake so the control FSM can stall MFHI/MFLO until a result is ready.

---
 rtl/mips_cpu_muldiv_pkg.sv | 26 ++
 rtl/mips_cpu_muldiv_signfix.sv | 43 ++++
 rtl/mips_cpu_muldiv_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// rtl/mips_cpu_muldiv_pkg.sv - op encoding, state encoding and constants for the HI/LO multiply/divide unit
package mips_cpu_muldiv_pkg;

    // Command encoding on the op port (rs/rt operands on a/b)
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_MFHI  = 3'b110,
        MD_MFLO  = 3'b111
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } md_state_e;

    // Quotient reported for a zero divisor; sliced down to WIDTH (WIDTH <= 64)
    localparam logic [63:0] MD_DIV0_QUOT = '1;

endpackage

// File: rtl/mips_cpu_muldiv_signfix.sv
// rtl/mips_cpu_muldiv_signfix.sv - operand magnitude conversion and result sign correction
import mips_cpu_muldiv_pkg::*;

module mips_cpu_muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               res_neg,
    output logic               rem_neg,
    input  logic [2*WIDTH-1:0] acc,
    input  logic               acc_res_neg,
    input  logic               acc_rem_neg,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem
);

    logic a_neg;
    logic b_neg;

    // Operand magnitudes and the signs the result must carry; the most negative
    // value maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        a_neg   = is_signed & a[WIDTH-1];
        b_neg   = is_signed & b[WIDTH-1];
        a_mag   = a_neg ? (~a + 1'b1) : a;
        b_mag   = b_neg ? (~b + 1'b1) : b;
        res_neg = a_neg ^ b_neg;
        rem_neg = a_neg;
    end

    // Re-apply signs to the unsigned product / quotient / remainder held in acc
    always_comb begin
        prod = acc_res_neg ? (~acc + 1'b1) : acc;
        quot = acc_res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem  = acc_rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// rtl/mips_cpu_muldiv_seq.sv - iterative MULT/DIV unit owning HI/LO; MIPS_CPU_MULDIV_FAST_MULT_EN selects a single-cycle multiply
import mips_cpu_muldiv_pkg::*;

module mips_cpu_muldiv_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             write,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int K     = BITS_PER_CYCLE;

    md_state_e          state;
    logic [2*WIDTH-1:0] acc;      // {remainder, quotient} or running product
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic [CNT_W-1:0]   cnt;
    logic               is_div_q;
    logic               res_neg_q;
    logic               rem_neg_q;
    logic               div0_q;

    logic               cmd_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               res_neg;
    logic               rem_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH+K-1:0] mul_upper;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH:0]     div_t;
    logic [2*WIDTH-1:0] div_next;

    assign busy       = (state != S_IDLE);
    assign cmd_signed = (op == MD_MULT) || (op == MD_DIV);

    mips_cpu_muldiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .a           (a),
        .b           (b),
        .is_signed   (cmd_signed),
        .a_mag       (a_mag),
        .b_mag       (b_mag),
        .res_neg     (res_neg),
        .rem_neg     (rem_neg),
        .acc         (acc),
        .acc_res_neg (res_neg_q),
        .acc_rem_neg (rem_neg_q),
        .prod        (prod_fix),
        .quot        (quot_fix),
        .rem         (rem_fix)
    );

    // Shift-add step: multiply the K low multiplier bits into the upper half, shift right by K
    always_comb begin
        mul_upper = {{K{1'b0}}, acc[2*WIDTH-1:WIDTH]}
                  + ({{K{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[K-1:0]});
        mul_next  = {mul_upper, acc[WIDTH-1:K]};
    end

    // Restoring divide step: retire K quotient bits, remainder stays below the divisor
    always_comb begin
        div_r = acc[2*WIDTH-1:WIDTH];
        div_q = acc[WIDTH-1:0];
        div_t = '0;
        for (int i = 0; i < K; i++) begin
            div_t = {div_r, div_q[WIDTH-1]};
            div_q = {div_q[WIDTH-2:0], 1'b0};
            if (div_t >= {1'b0, opnd}) begin
                div_t    = div_t - {1'b0, opnd};
                div_q[0] = 1'b1;
            end
            div_r = div_t[WIDTH-1:0];
        end
        div_next = {div_r, div_q};
    end

    // Command acceptance, iteration sequencing and HI/LO ownership
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (write) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                is_div_q  <= 1'b0;
                                res_neg_q <= res_neg;
                                rem_neg_q <= rem_neg;
                                div0_q    <= 1'b0;
                                cnt       <= '0;
                                opnd      <= a_mag;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                                acc       <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                                state     <= S_FIXUP;
`else
                                acc       <= {{WIDTH{1'b0}}, b_mag};
                                state     <= S_RUN;
`endif
                            end
                            MD_DIV, MD_DIVU: begin
                                is_div_q  <= 1'b1;
                                res_neg_q <= res_neg;
                                rem_neg_q <= rem_neg;
                                div0_q    <= (b == '0);
                                cnt       <= '0;
                                opnd      <= b_mag;
                                acc       <= {{WIDTH{1'b0}}, a_mag};
                                state     <= S_RUN;
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc <= is_div_q ? div_next : mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (is_div_q) begin
                        lo <= div0_q ? MD_DIV0_QUOT[WIDTH-1:0] : quot_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
